// File: rtl/frame_pkg.sv
// Shared definitions for the frame generator and frame checker:
// state encodings, default constants, error-injection modes and word packing.
package frame_pkg;

    // FSM states are one-hot so they can be exported directly on `control`.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SEND  = 4'b0010,
        ST_STALL = 4'b0100
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_HDR  = 2'b01,
        ERR_SEQ  = 2'b10,
        ERR_BOTH = 2'b11
    } err_mode_t;

    localparam logic [3:0]  DEFAULT_HEADER    = 4'hF;
    localparam logic [15:0] DEFAULT_IDLE_WORD = 16'h0000;
    localparam int          DEFAULT_FRAME_LEN = 4;

    function automatic logic [15:0] pack_word(input logic [3:0] hdr,
                                              input logic [7:0] payload,
                                              input logic [3:0] seq);
        return {hdr, payload, seq};
    endfunction

    function automatic logic err_hdr(input logic [1:0] mode);
        return (mode == ERR_HDR) || (mode == ERR_BOTH);
    endfunction

    function automatic logic err_seq(input logic [1:0] mode);
        return (mode == ERR_SEQ) || (mode == ERR_BOTH);
    endfunction

endpackage

// File: rtl/frame_seq_counter.sv
// Sequence counter for frame words: counts 0..FRAME_LEN-1 on enable and wraps.
// Shared by the generator and the checker's expected-sequence tracking.
module frame_seq_counter
    import frame_pkg::*;
#(
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] seq,
    output logic       is_last
);

    localparam logic [3:0] LAST_SEQ = 4'(FRAME_LEN - 1);

    assign is_last = (seq == LAST_SEQ);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            seq <= 4'd0;
        end else if (enable) begin
            seq <= is_last ? 4'd0 : seq + 4'd1;
        end
    end

endmodule

// File: rtl/frame_generator.sv
// Transmit-side frame generator: packs payload bytes into {hdr, payload, seq}
// words, FRAME_LEN words per frame, with optional header/sequence corruption.
module frame_generator
    import frame_pkg::*;
#(
    parameter logic [3:0]  HEADER    = DEFAULT_HEADER,
    parameter int          FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter logic [15:0] IDLE_WORD = DEFAULT_IDLE_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic [1:0]  err_mode,
    output logic        data_ready,
    output logic [15:0] bus_out,
    output logic        bus_valid,
    output logic        frame_done,
    output logic [3:0]  control
);

    localparam logic [3:0] BAD_SEQ = 4'(FRAME_LEN);

    state_t     state;
    logic [3:0] seq;
    logic       is_last;
    logic       accept;
    logic [3:0] hdr_field;
    logic [3:0] seq_field;

    // Handshake: a byte is transferred on any cycle where data_valid and
    // data_ready are both high; data_ready depends only on the state register.
    assign data_ready = (state != ST_IDLE);
    assign accept     = data_valid && data_ready;
    assign control    = state;

    // Injected faults only alter the emitted word; the counter keeps counting.
    assign hdr_field = err_hdr(err_mode) ? ~HEADER : HEADER;
    assign seq_field = err_seq(err_mode) ? BAD_SEQ : seq;

    frame_seq_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_seq (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_IDLE),
        .enable  (accept),
        .seq     (seq),
        .is_last (is_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bus_out    <= IDLE_WORD;
            bus_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus_out    <= IDLE_WORD;
                    bus_valid  <= 1'b0;
                    frame_done <= 1'b0;
                    if (start) begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND, ST_STALL: begin
                    if (accept) begin
                        bus_out    <= pack_word(hdr_field, data_in, seq_field);
                        bus_valid  <= 1'b1;
                        frame_done <= is_last;
                        // Holding start on the last word chains frames with no gap.
                        if (is_last && !start) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_SEND;
                        end
                    end else begin
                        bus_out    <= IDLE_WORD;
                        bus_valid  <= 1'b0;
                        frame_done <= 1'b0;
                        state      <= ST_STALL;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    bus_out    <= IDLE_WORD;
                    bus_valid  <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_generator.sv
// Bench for frame_generator: directed scenarios then random traffic,
// compared cycle by cycle against a frame-level behavioural model.
module tb_frame_generator;

    localparam logic [3:0]  HEADER    = 4'hF;
    localparam int          FRAME_LEN = 4;
    localparam logic [15:0] IDLE_WORD = 16'h0000;
    localparam int          W         = 22;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic [1:0]  err_mode = 2'b00;
    logic        data_ready;
    logic [15:0] bus_out;
    logic        bus_valid;
    logic        frame_done;
    logic [3:0]  control;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    // Model state: mode 0 = waiting for start, 1 = in frame, 2 = in frame after a gap.
    int m_mode = 0;
    int m_words = 0;

    frame_generator #(
        .HEADER    (HEADER),
        .FRAME_LEN (FRAME_LEN),
        .IDLE_WORD (IDLE_WORD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .err_mode   (err_mode),
        .data_ready (data_ready),
        .bus_out    (bus_out),
        .bus_valid  (bus_valid),
        .frame_done (frame_done),
        .control    (control)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_cycle(input logic s, input logic dv,
                                                 input logic [7:0] d, input logic [1:0] em);
        logic [15:0] word;
        logic        done;
        int          hdr;
        int          sq;
        word = IDLE_WORD;
        done = 1'b0;
        if (m_mode == 0) begin
            if (s) m_mode = 1;
            return {IDLE_WORD, 1'b0, 1'b0, 4'b0001 << m_mode};
        end
        if (!dv) begin
            m_mode = 2;
            return {IDLE_WORD, 1'b0, 1'b0, 4'b0100};
        end
        hdr  = em[0] ? (15 - HEADER) : HEADER;
        sq   = em[1] ? FRAME_LEN : m_words;
        word = 16'(hdr * 4096 + d * 16 + sq);
        done = (m_words == FRAME_LEN - 1);
        m_words = (m_words + 1) % FRAME_LEN;
        m_mode = (done && !s) ? 0 : 1;
        return {word, 1'b1, done, 4'b0001 << m_mode};
    endfunction

    task automatic step(input logic s, input logic dv, input logic [7:0] d, input logic [1:0] em);
        logic [W-1:0] e;
        start = s;
        data_valid = dv;
        data_in = d;
        err_mode = em;
        #1;
        check("data_ready", {31'd0, data_ready}, {31'd0, (m_mode != 0)});
        exp_q.push_back(model_cycle(s, dv, d, em));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("bus_out", {16'd0, bus_out}, {16'd0, e[21:6]});
        check("bus_valid", {31'd0, bus_valid}, {31'd0, e[5]});
        check("frame_done", {31'd0, frame_done}, {31'd0, e[4]});
        check("control", {28'd0, control}, {28'd0, e[3:0]});
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        start = 1'b0;
        data_valid = 1'b0;
        err_mode = 2'b00;
        repeat (cycles) @(posedge clk);
        #1;
        m_mode = 0;
        m_words = 0;
        check("rst_bus_out", {16'd0, bus_out}, {16'd0, IDLE_WORD});
        check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_data_ready", {31'd0, data_ready}, 32'd0);
        check("rst_control", {28'd0, control}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset(3);

        // Plain frame, then idle
        step(1, 0, 8'h00, 2'b00);
        repeat (4) step(0, 1, 8'hAE, 2'b00);
        step(0, 1, 8'h55, 2'b00);

        // Stall after second word
        step(1, 1, 8'h11, 2'b00);
        repeat (2) step(0, 1, 8'hAE, 2'b00);
        repeat (2) step(0, 0, 8'hAE, 2'b00);
        repeat (2) step(0, 1, 8'hAE, 2'b00);

        // Header corruption on last word, sequence corruption on first word
        step(1, 0, 8'h00, 2'b00);
        repeat (3) step(0, 1, 8'hAE, 2'b00);
        step(0, 1, 8'hAE, 2'b01);
        step(1, 0, 8'h00, 2'b00);
        step(0, 1, 8'hAE, 2'b10);
        repeat (3) step(0, 1, 8'hAE, 2'b00);

        // Back-to-back frames with start held
        step(1, 1, 8'hAE, 2'b00);
        repeat (11) step(1, 1, 8'hAE, 2'b00);
        step(0, 1, 8'hAE, 2'b00);

        // Reset mid-frame restarts the sequence
        step(1, 0, 8'h00, 2'b00);
        repeat (2) step(0, 1, 8'hAE, 2'b00);
        do_reset(1);
        step(1, 0, 8'h00, 2'b00);
        repeat (4) step(0, 1, 8'hAE, 2'b00);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                step(($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) != 0),
                     8'($urandom_range(0, 255)),
                     ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frame_generator.md
Name: frame_generator

Overview:
Transmit-side counterpart of the frame checker state machine. Packs 8-bit payload bytes into 16-bit bus words: 4-bit header in [15:12], payload in [11:4], sequence number in [3:0].
Emits frames of FRAME_LEN words with sequence numbers 0..FRAME_LEN-1. Drives the 16-bit word bus that feeds the checker.
Includes a deliberate error-injection mode so the checker's error path can be exercised from real traffic.

Parameters:
HEADER, 4'hF, header nibble placed in bus_out[15:12] of every valid word
FRAME_LEN, 4, words per frame; legal range 2..15
IDLE_WORD, 16'h0000, value on bus_out whenever no word is emitted

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to begin a frame; level-sampled
data_in  input  8  payload byte for next word
data_valid  input  1  data_in is valid this cycle
err_mode  input  2  00 none, 01 corrupt header, 10 corrupt sequence, 11 both; sampled with accepted word
data_ready  output  1  block accepts data_in this cycle
bus_out  output  16  registered word {hdr, payload, seq}
bus_valid  output  1  bus_out carries a frame word
frame_done  output  1  one-cycle pulse coincident with last word of frame
control  output  4  one-hot FSM state: IDLE 4'b0001, SEND 4'b0010, STALL 4'b0100

Behaviour:
- Reset (synchronous, active-high, on clk rising edge) sets:
  - state = IDLE; seq = 0
  - bus_out = IDLE_WORD; bus_valid = 0; frame_done = 0
  - data_ready deasserts as a result of state = IDLE.
- Reset mid-frame abandons the frame; the next frame restarts at seq 0.
- data_ready = 1 in SEND and STALL, 0 in IDLE. It is a combinational decode of the state register.
- An accept is data_valid && data_ready.
- IDLE:
  - start=1 -> SEND next cycle; otherwise stay in IDLE.
  - data_valid is ignored in IDLE, including when it coincides with start; no word is accepted in that cycle.
- SEND/STALL, on accept:
  - Next edge: bus_out = {hdr, data_in, seqf}, bus_valid = 1, state = SEND. Latency is exactly 1 cycle.
  - hdr = HEADER, or ~HEADER when err_mode[0]=1 (4'h0 for the default).
  - seqf = seq, or FRAME_LEN when err_mode[1]=1 (an out-of-range value).
  - The internal seq always advances normally, regardless of err_mode.
- SEND/STALL, no accept:
  - Next edge: bus_out = IDLE_WORD, bus_valid = 0, state = STALL, seq held.
- Last word (accept with seq == FRAME_LEN-1):
  - seq wraps to 0; frame_done = 1 for one cycle, alongside that word.
  - If start=1 in the same cycle: state = SEND, for a back-to-back frame with no gap word.
  - Otherwise: state = IDLE.
- control reflects the registered state. It is not updated mid-cycle.
- Outputs are fully registered, except data_ready.
- In IDLE: bus_out = IDLE_WORD, bus_valid = 0, frame_done = 0.

Decomposition:
- Package frame_pkg holds:
  - state encodings ST_IDLE / ST_SEND / ST_STALL
  - default HEADER and IDLE_WORD constants
  - err_mode encodings ERR_NONE / ERR_HDR / ERR_SEQ / ERR_BOTH
- The checker and this block import the same package.
- One sub-module: frame_seq_counter.
  - 4-bit counter with enable, synchronous clear and wrap at FRAME_LEN-1.
  - Outputs seq and is_last.
  - Reused by the checker for its expected-sequence tracking.

Test Plan:
1. Reset high 3 cycles, then low -> bus_out=0000, bus_valid=0, frame_done=0, data_ready=0, control=0001.
2. start=1 one cycle, then data_in=8'hAE, data_valid=1 for 4 cycles -> bus_out FAE0, FAE1, FAE2, FAE3 on consecutive cycles; frame_done only with FAE3; control returns to 0001.
3. Same frame, with data_valid=0 for 2 cycles after second word -> FAE0, FAE1, 0000, 0000 (control=0100, bus_valid=0), FAE2, FAE3.
4. err_mode=01 on fourth word -> FAE0, FAE1, FAE2, 0AE3, with frame_done still asserted. err_mode=10 on first word of next frame -> FAE4, then FAE1 (seq unaffected).
5. start held high with continuous data_valid -> FAE3 immediately followed by FAE0 in the next cycle; no 0000 gap; frame_done pulses every 4 cycles.
6. Reset asserted after FAE1 of a frame -> next cycle bus_out=0000, control=0001. New start then yields FAE0 (seq restarted).
